// File: rtl/sync_fifo_ctrl_if.sv
// Producer, consumer and dual-port RAM pins of the FIFO controller bundled together.
// The slave modport is the controller's view; the master modport is its environment's.
interface sync_fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
);
  logic                  flush_i;
  logic                  wr_valid_i;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  wr_ready_o;
  logic                  rd_req_i;
  logic                  rd_valid_o;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  full_o;
  logic                  empty_o;
  logic                  almost_full_o;
  logic                  almost_empty_o;
  logic [ADDR_WIDTH:0]   count_o;
  logic                  overflow_o;
  logic                  underflow_o;
  logic                  ram_cs_o;
  logic                  ram_wren1_o;
  logic [ADDR_WIDTH-1:0] ram_addr1_o;
  logic [DATA_WIDTH-1:0] ram_wr_data1_o;
  logic                  ram_wren2_o;
  logic [ADDR_WIDTH-1:0] ram_addr2_o;
  logic [DATA_WIDTH-1:0] ram_rd_data2_i;

  modport slave (
    input  flush_i, wr_valid_i, wr_data_i, rd_req_i, ram_rd_data2_i,
    output wr_ready_o, rd_valid_o, rd_data_o, full_o, empty_o, almost_full_o,
           almost_empty_o, count_o, overflow_o, underflow_o, ram_cs_o, ram_wren1_o,
           ram_addr1_o, ram_wr_data1_o, ram_wren2_o, ram_addr2_o
  );

  modport master (
    output flush_i, wr_valid_i, wr_data_i, rd_req_i, ram_rd_data2_i,
    input  wr_ready_o, rd_valid_o, rd_data_o, full_o, empty_o, almost_full_o,
           almost_empty_o, count_o, overflow_o, underflow_o, ram_cs_o, ram_wren1_o,
           ram_addr1_o, ram_wr_data1_o, ram_wren2_o, ram_addr2_o
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller over a 1-cycle-latency dual-port RAM: pop data valid one cycle
// after an accepted pop; pushes are refused (wr_ready_o low) while full, pops ignored while empty.
module sync_fifo_ctrl #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 8,
  parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input logic               clk,
  input logic               rst_n,
  sync_fifo_ctrl_if.slave   bus
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_LVL  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_LVL = PW'(AEMPTY_THRESH);

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  rd_valid_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic [DATA_WIDTH-1:0] wr_word;

  // The extra MSB on each pointer tells full from empty when the addresses match.
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                 (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  assign push    = bus.wr_valid_i && !full  && !bus.flush_i;
  assign pop     = bus.rd_req_i   && !empty && !bus.flush_i;
  assign wr_word = bus.wr_data_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      // A pop accepted just before a flush still delivers its word.
      rd_valid_q <= pop;
      if (bus.flush_i) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (bus.wr_valid_i && full)  overflow_q  <= 1'b1;
        if (bus.rd_req_i   && empty) underflow_q <= 1'b1;
      end
    end
  end

  assign bus.wr_ready_o     = rst_n && !full;
  assign bus.rd_valid_o     = rd_valid_q;
  assign bus.rd_data_o      = bus.ram_rd_data2_i;
  assign bus.full_o         = full;
  assign bus.empty_o        = empty;
  assign bus.almost_full_o  = (count >= AFULL_LVL);
  assign bus.almost_empty_o = (count <= AEMPTY_LVL);
  assign bus.count_o        = count;
  assign bus.overflow_o     = overflow_q;
  assign bus.underflow_o    = underflow_q;

  assign bus.ram_cs_o       = push || pop;
  assign bus.ram_wren1_o    = push;
  assign bus.ram_addr1_o    = wr_ptr[ADDR_WIDTH-1:0];
  assign bus.ram_wr_data1_o = wr_word;
  assign bus.ram_wren2_o    = 1'b0;
  assign bus.ram_addr2_o    = rd_ptr[ADDR_WIDTH-1:0];
endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Pointer, flag and handshake controller that turns the dual-port synchronous RAM (dp_ram) into a single-clock FIFO.
- Port 1 of the RAM is used only for writes; port 2 is used only for reads.
- Sits between a producer (valid/ready push side) and a consumer (request/valid pop side). Drives the RAM's chip-select, write-enable and address pins, and returns RAM port-2 read data to the consumer.

Parameters:
- ADDR_WIDTH, 10, RAM address width; FIFO depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, data word width.
- AFULL_THRESH, 2**ADDR_WIDTH-2, almost_full_o asserts when count_o >= this value.
- AEMPTY_THRESH, 2, almost_empty_o asserts when count_o <= this value.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous flush: empties the FIFO and clears the error flags.
- wr_valid_i  input  1  producer offers wr_data_i.
- wr_data_i  input  DATA_WIDTH  push data.
- wr_ready_o  output  1  FIFO can accept a push (= !full_o).
- rd_req_i  input  1  consumer pop request.
- rd_valid_o  output  1  rd_data_o is valid this cycle.
- rd_data_o  output  DATA_WIDTH  pop data (direct pass-through of ram_rd_data2_i).
- full_o, empty_o, almost_full_o, almost_empty_o  output  1 each  status flags.
- count_o  output  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.
- overflow_o, underflow_o  output  1 each  sticky error flags.
- ram_cs_o  output  1  to RAM cs_i.
- ram_wren1_o  output  1  to RAM wren1_i.
- ram_addr1_o  output  ADDR_WIDTH  to RAM addr1_i.
- ram_wr_data1_o  output  DATA_WIDTH  to RAM wr_data1_i.
- ram_wren2_o  output  1  to RAM wren2_i; tied to 0.
- ram_addr2_o  output  ADDR_WIDTH  to RAM addr2_i.
- ram_rd_data2_i  input  DATA_WIDTH  from RAM rd_data2_o.

Behaviour:
- **Reset:** rst_n low asynchronously clears the following. Outputs then take these values:
  - wr_ptr = rd_ptr = 0 (both ADDR_WIDTH+1 bits, MSB is the wrap bit).
  - count_o = 0, rd_valid_o = 0, overflow_o = 0, underflow_o = 0.
  - empty_o = 1, almost_empty_o = 1, full_o = 0, almost_full_o = 0, wr_ready_o = 0 while rst_n is low.
- **Push accept:** push = wr_valid_i & !full_o & !flush_i.
  - ram_wren1_o = push.
  - ram_addr1_o = wr_ptr[ADDR_WIDTH-1:0].
  - ram_wr_data1_o = wr_data_i.
  - wr_ptr increments on the following edge.
- **Pop accept:** pop = rd_req_i & !empty_o & !flush_i.
  - ram_addr2_o = rd_ptr[ADDR_WIDTH-1:0].
  - rd_ptr increments on the following edge.
  - rd_valid_o is a register loaded with pop, so it is high exactly one cycle after an accepted pop. RAM read latency is 1 cycle.
- **Chip select:** ram_cs_o = push | pop (combinational). RAM port outputs are combinational from registered pointers and the current inputs.
- **Flags** (all combinational from the registered pointers):
  - empty_o = (wr_ptr == rd_ptr).
  - full_o = (addresses equal) & (wrap bits differ).
  - count_o = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1).
- **Pointer wrap-around:** pointers wrap naturally at 2**(ADDR_WIDTH+1); addresses wrap at 2**ADDR_WIDTH.
- **Simultaneous push and pop:**
  - Both accepted when neither full nor empty; count unchanged.
  - When full: pop accepted, push rejected (wr_ready_o = 0). No same-cycle pass-through.
  - When empty: push accepted, pop rejected. No bypass; data becomes readable from the next cycle.
  - A write-address/read-address collision on an accepted operation cannot occur. Verification asserts this.
- **Error flags:**
  - overflow_o sets on wr_valid_i & full_o.
  - underflow_o sets on rd_req_i & empty_o.
  - Both are sticky until flush_i or reset.
  - Rejected operations never move pointers.
- **Flush:** flush_i has priority over push and pop in the same cycle. On the next edge:
  - Pointers reset to 0 and the error flags clear.
  - rd_valid_o for a pop accepted in the cycle before the flush still asserts, with that pop's data.
- **Reset mid-operation:** an in-flight rd_valid_o is dropped immediately. All stored contents are considered lost. RAM contents are not cleared.

Test Plan:
- Reset, then idle: empty_o = 1, count_o = 0, wr_ready_o = 1, rd_valid_o = 0, ram_cs_o = 0.
- Push 0xAB, 0xCD, 0xEF on consecutive cycles; then pop 3 times:
  - rd_valid_o is high on the 3 cycles after each pop, carrying 0xAB, 0xCD, 0xEF.
  - count_o goes 1, 2, 3 during the pushes and back to 0 after the pops; empty_o = 1 at the end.
- ADDR_WIDTH = 2, fill to 4 entries:
  - full_o = 1 and wr_ready_o = 0; almost_full_o asserted from count 2.
  - A 5th push sets overflow_o and count stays 4.
  - A flush clears overflow_o and count_o.
- ADDR_WIDTH = 2, steady push + pop every cycle for 20 cycles with incrementing data:
  - Output sequence equals the input sequence delayed.
  - Pointers wrap multiple times; count_o is constant.
- Full FIFO with push + pop in the same cycle: pop data is correct, push rejected, count 4 goes to 3.
- Empty FIFO with push + pop in the same cycle: pop rejected, underflow_o = 1, count 0 goes to 1.
- Assert rst_n low during a pop: rd_valid_o is 0 immediately, and all flags return to their reset values.
